// File: rtl/div_result_bcd_if.sv
// rtl/div_result_bcd_if.sv - request/result bundle between the divider and the BCD converter
interface div_result_bcd_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [WIDTH-1:0]      value;
   logic                  ovf_in;
   logic [4*DIGITS-1:0]   bcd;
   logic                  valid;
   logic                  busy;
   logic                  err;

   // requester side: issues conversions and observes results
   modport master (
      output start, value, ovf_in,
      input  bcd, valid, busy, err
   );

   // converter side
   modport slave (
      input  start, value, ovf_in,
      output bcd, valid, busy, err
   );
endinterface

// File: rtl/div_result_bcd.sv
// rtl/div_result_bcd.sv - sequential double-dabble binary to packed BCD with overflow passthrough
module div_result_bcd #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic            clk,
   input  logic            reset_a,
   div_result_bcd_if.slave bus
);
   localparam int SW = DIGITS * 4 + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [SW-1:0]       sreg;
   logic [SW-1:0]       adj;
   logic [SW-1:0]       shifted;
   logic [CW-1:0]       cnt;
   logic [4*DIGITS-1:0] bcd_q;
   logic                valid_q;
   logic                busy_q;
   logic                err_q;

   assign bus.bcd   = bcd_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

   // state register
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) state <= IDLE;
      else          state <= state_nx;
   end

   // next state: start only matters in IDLE, so requests while busy are dropped
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = bus.ovf_in ? FAULT : SHIFT;
         SHIFT:   if (cnt == LAST) state_nx = IDLE;
         FAULT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // one double-dabble step: add 3 to every digit >= 5, then shift left one bit
   always_comb begin
      adj = sreg;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[WIDTH + 4*i +: 4] >= 4'd5)
            adj[WIDTH + 4*i +: 4] = adj[WIDTH + 4*i +: 4] + 4'd3;
      end
      shifted = adj << 1;
   end

   // datapath and registered outputs; valid defaults low so it is a single-cycle pulse
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         sreg    <= '0;
         cnt     <= '0;
         bcd_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (!bus.ovf_in) begin
                     sreg <= {{(DIGITS*4){1'b0}}, bus.value};
                     cnt  <= '0;
                  end
               end
            end
            SHIFT: begin
               sreg <= shifted;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bcd_q   <= shifted[SW-1:WIDTH];
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            FAULT: begin
               bcd_q   <= '1;
               err_q   <= 1'b1;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: busy_q <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_div_result_bcd.sv
// tb/tb_div_result_bcd.sv - directed self-checking bench for div_result_bcd
module tb_div_result_bcd;
   logic clk = 1'b0;
   logic reset_a = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   lat;
   int   npulse;

   always #5 clk = ~clk;

   div_result_bcd_if #(.WIDTH(16), .DIGITS(5)) bus ();

   div_result_bcd #(.WIDTH(16), .DIGITS(5)) dut (
      .clk     (clk),
      .reset_a (reset_a),
      .bus     (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // drive a one-cycle start pulse; returns at the negedge after the accepting edge
   task automatic pulse_start(input logic [15:0] v, input logic o);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.value  = v;
      bus.ovf_in = o;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.value  = 16'($urandom);
      bus.ovf_in = 1'($urandom);
   endtask

   // count clocks after the accepting edge until valid is seen (bounded)
   task automatic wait_valid(output int n);
      n = 0;
      while (bus.valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic conv(input string tag, input logic [15:0] v, input logic [19:0] exp_bcd);
      pulse_start(v, 1'b0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_valid(lat);
      check({tag, "_lat"}, 32'(lat), 32'd16);
      check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
      check({tag, "_err"}, 32'(bus.err), 32'd0);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.value  = '0;
      bus.ovf_in = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_bcd", 32'(bus.bcd), 32'h0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      reset_a = 1'b1;

      // basic conversions
      conv("v2", 16'd2, 20'h00002);
      conv("v65535", 16'd65535, 20'h65535);
      conv("v1234", 16'd1234, 20'h01234);
      conv("v0", 16'd0, 20'h00000);

      // overflow passthrough
      pulse_start(16'hABCD, 1'b1);
      check("ovf_busy", 32'(bus.busy), 32'd1);
      check("ovf_valid_early", 32'(bus.valid), 32'd0);
      wait_valid(lat);
      check("ovf_lat", 32'(lat), 32'd1);
      check("ovf_bcd", 32'(bus.bcd), 32'hFFFFF);
      check("ovf_err", 32'(bus.err), 32'd1);
      check("ovf_busy_done", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("ovf_valid_drop", 32'(bus.valid), 32'd0);
      check("ovf_bcd_hold", 32'(bus.bcd), 32'hFFFFF);

      // start while busy is ignored
      pulse_start(16'd999, 1'b0);
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.value = 16'd7; bus.ovf_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 5;
      while (bus.valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("busy_lat", 32'(lat), 32'd16);
      check("busy_bcd", 32'(bus.bcd), 32'h00999);
      npulse = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.valid === 1'b1) npulse++;
      end
      check("busy_no_second", 32'(npulse), 32'd0);
      check("busy_bcd_hold", 32'(bus.bcd), 32'h00999);

      // reset mid-conversion
      pulse_start(16'd500, 1'b0);
      repeat (7) @(negedge clk);
      reset_a = 1'b0;
      #1;
      check("mid_rst_bcd", 32'(bus.bcd), 32'h0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_valid", 32'(bus.valid), 32'd0);
      check("mid_rst_err", 32'(bus.err), 32'd0);
      @(negedge clk);
      reset_a = 1'b1;
      npulse = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.valid === 1'b1) npulse++;
      end
      check("mid_rst_no_valid", 32'(npulse), 32'd0);
      conv("v42", 16'd42, 20'h00042);

      // back-to-back: new start on the valid cycle
      pulse_start(16'd10, 1'b0);
      wait_valid(lat);
      check("b2b_lat1", 32'(lat), 32'd16);
      check("b2b_bcd1", 32'(bus.bcd), 32'h00010);
      bus.start = 1'b1; bus.value = 16'd300; bus.ovf_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_busy2", 32'(bus.busy), 32'd1);
      wait_valid(lat);
      check("b2b_lat2", 32'(lat), 32'd16);
      check("b2b_bcd2", 32'(bus.bcd), 32'h00300);
      check("b2b_err2", 32'(bus.err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
